// File: rtl/pc_ctrl_pkg.sv
// Shared MIPS fetch definitions: PC controller state encoding and the
// instruction byte stride used for sequential fetch and link values.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } pc_state_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage : pc_ctrl_pkg

// File: rtl/pc_next_sel.sv
// Next-PC target selection: JR > J/JAL > taken branch > sequential.
// Flags a selected non-sequential target that is misaligned or outside
// instruction memory, and flags a sequential step that wraps to address 0.
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned SIZE_ADDR_PC = 32,
    parameter int unsigned IMEM_DEPTH   = 256
) (
    input  logic [SIZE_ADDR_PC-1:0] i_pc,
    input  logic                    i_jr,
    input  logic [SIZE_ADDR_PC-1:0] i_jr_addr,
    input  logic                    i_jump,
    input  logic [SIZE_ADDR_PC-1:0] i_jump_addr,
    input  logic                    i_branch_taken,
    input  logic [SIZE_ADDR_PC-1:0] i_branch_addr,
    output logic [SIZE_ADDR_PC-1:0] o_next_pc,
    output logic                    o_fault,
    output logic                    o_wrap
);

    // IMEM_DEPTH is a power of two, so the byte range is a simple mask
    localparam logic [SIZE_ADDR_PC-1:0] ADDR_MASK =
        SIZE_ADDR_PC'(IMEM_DEPTH * INSTR_BYTES - 1);

    logic [SIZE_ADDR_PC-1:0] w_seq_pc;
    logic [SIZE_ADDR_PC-1:0] w_sel;
    logic                    w_nonseq;

    assign w_seq_pc = (i_pc + SIZE_ADDR_PC'(INSTR_BYTES)) & ADDR_MASK;

    // Priority mux over the redirect sources, falling back to sequential fetch
    always_comb begin
        w_sel    = w_seq_pc;
        w_nonseq = 1'b1;
        if (i_jr) begin
            w_sel = i_jr_addr;
        end else if (i_jump) begin
            w_sel = i_jump_addr;
        end else if (i_branch_taken) begin
            w_sel = i_branch_addr;
        end else begin
            w_nonseq = 1'b0;
        end
    end

    assign o_next_pc = w_sel;
    assign o_fault   = w_nonseq & ((|w_sel[1:0]) | (|(w_sel & ~ADDR_MASK)));
    assign o_wrap    = ~w_nonseq & (w_seq_pc == '0);

endmodule : pc_next_sel

// File: rtl/pc_ctrl.sv
// Program counter controller: continuous run or single-step debug, hazard
// stall, redirect priority, HALT/resume, terminal FAULT on bad targets,
// wrap pulse on sequential rollover and a saturating advance counter.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned               SIZE_ADDR_PC = 32,
    parameter int unsigned               IMEM_DEPTH   = 256,
    parameter logic [SIZE_ADDR_PC-1:0]   RESET_ADDR   = '0,
    parameter int unsigned               SIZE_CNT     = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_mode,
    input  logic                    i_step,
    input  logic                    i_pc_write,
    input  logic                    i_branch_taken,
    input  logic [SIZE_ADDR_PC-1:0] i_branch_addr,
    input  logic                    i_jump,
    input  logic [SIZE_ADDR_PC-1:0] i_jump_addr,
    input  logic                    i_jr,
    input  logic [SIZE_ADDR_PC-1:0] i_jr_addr,
    input  logic                    i_halt,
    input  logic                    i_resume,
    output logic [SIZE_ADDR_PC-1:0] o_pc,
    output logic [SIZE_ADDR_PC-1:0] o_pc_4,
    output logic [SIZE_ADDR_PC-1:0] o_pc_8,
    output logic                    o_halted,
    output logic                    o_fault,
    output logic                    o_wrap,
    output logic [SIZE_CNT-1:0]     o_adv_count
);

    pc_state_e               r_state;
    logic [SIZE_ADDR_PC-1:0] r_pc;
    logic [SIZE_CNT-1:0]     r_adv_count;
    logic                    r_wrap;
    logic                    r_halted;
    logic                    r_fault;
    logic                    r_step_q;

    logic                    w_step_edge;
    logic                    w_adv;
    logic [SIZE_ADDR_PC-1:0] w_next_pc;
    logic                    w_tgt_fault;
    logic                    w_seq_wrap;

    // A step edge is consumed in the cycle it appears, whether or not it advances
    assign w_step_edge = i_step & ~r_step_q;
    assign w_adv       = (r_state == ST_RUN) & i_pc_write & (~i_mode | w_step_edge);

    pc_next_sel #(
        .SIZE_ADDR_PC (SIZE_ADDR_PC),
        .IMEM_DEPTH   (IMEM_DEPTH)
    ) u_next_sel (
        .i_pc           (r_pc),
        .i_jr           (i_jr),
        .i_jr_addr      (i_jr_addr),
        .i_jump         (i_jump),
        .i_jump_addr    (i_jump_addr),
        .i_branch_taken (i_branch_taken),
        .i_branch_addr  (i_branch_addr),
        .o_next_pc      (w_next_pc),
        .o_fault        (w_tgt_fault),
        .o_wrap         (w_seq_wrap)
    );

    // Delayed copy of the step request for rising-edge detection
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= i_step;
        end
    end

    // Run/halt/fault FSM with PC, counter and status flags registered alongside
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_ADDR;
            r_adv_count <= '0;
            r_wrap      <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_adv) begin
                        if (i_halt) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (w_tgt_fault) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc   <= w_next_pc;
                            r_wrap <= w_seq_wrap;
                            if (r_adv_count != '1) begin
                                r_adv_count <= r_adv_count + SIZE_CNT'(1);
                            end
                        end
                    end
                end
                ST_HALT: begin
                    if (i_resume) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state  <= ST_FAULT;
                    r_halted <= 1'b0;
                    r_fault  <= 1'b1;
                end
            endcase
        end
    end

    assign o_pc        = r_pc;
    assign o_pc_4      = r_pc + SIZE_ADDR_PC'(INSTR_BYTES);
    assign o_pc_8      = r_pc + SIZE_ADDR_PC'(2 * INSTR_BYTES);
    assign o_halted    = r_halted;
    assign o_fault     = r_fault;
    assign o_wrap      = r_wrap;
    assign o_adv_count = r_adv_count;

endmodule : pc_ctrl

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed vector table, hand-written multi-cycle
// sequences, randomized run against a reference model, and a small
// second instance for wrap and counter saturation.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode, step, pc_write, br, jmp, jr, halt, resume;
    logic [31:0] br_addr, jmp_addr, jr_addr;
    logic [31:0] pc, pc4, pc8, cnt;
    logic        halted, fault, wrap;

    logic        rst2_n;
    logic [31:0] d2_pc, d2_pc4, d2_pc8;
    logic        d2_halted, d2_fault, d2_wrap;
    logic [2:0]  d2_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    int          m_state;   // 0 run, 1 halt, 2 fault
    logic        m_stepq;
    logic        m_wrap;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .i_clk(clk), .i_reset(rst_n), .i_mode(mode), .i_step(step),
        .i_pc_write(pc_write), .i_branch_taken(br), .i_branch_addr(br_addr),
        .i_jump(jmp), .i_jump_addr(jmp_addr), .i_jr(jr), .i_jr_addr(jr_addr),
        .i_halt(halt), .i_resume(resume), .o_pc(pc), .o_pc_4(pc4), .o_pc_8(pc8),
        .o_halted(halted), .o_fault(fault), .o_wrap(wrap), .o_adv_count(cnt)
    );

    pc_ctrl #(.IMEM_DEPTH(4), .SIZE_CNT(3)) dut2 (
        .i_clk(clk), .i_reset(rst2_n), .i_mode(1'b0), .i_step(1'b0),
        .i_pc_write(1'b1), .i_branch_taken(1'b0), .i_branch_addr(32'h0),
        .i_jump(1'b0), .i_jump_addr(32'h0), .i_jr(1'b0), .i_jr_addr(32'h0),
        .i_halt(1'b0), .i_resume(1'b0), .o_pc(d2_pc), .o_pc_4(d2_pc4), .o_pc_8(d2_pc8),
        .o_halted(d2_halted), .o_fault(d2_fault), .o_wrap(d2_wrap), .o_adv_count(d2_cnt)
    );

    typedef struct {
        logic        pcw, jr, jmp, br, halt, resume;
        logic [31:0] jr_a, jmp_a, br_a;
        logic [31:0] e_pc;
        logic        e_halted, e_fault, e_wrap;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic pcw, logic jr_i, logic [31:0] jra, logic jmp_i,
                                logic [31:0] jmpa, logic br_i, logic [31:0] bra,
                                logic hlt, logic res, logic [31:0] epc, logic eh,
                                logic ef, logic ew, logic [31:0] ecnt);
        vec_t v;
        v.pcw = pcw; v.jr = jr_i; v.jr_a = jra; v.jmp = jmp_i; v.jmp_a = jmpa;
        v.br = br_i; v.br_a = bra; v.halt = hlt; v.resume = res;
        v.e_pc = epc; v.e_halted = eh; v.e_fault = ef; v.e_wrap = ew; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        mode = 1'b0; step = 1'b0; pc_write = 1'b1;
        br = 1'b0; jmp = 1'b0; jr = 1'b0; halt = 1'b0; resume = 1'b0;
        br_addr = '0; jmp_addr = '0; jr_addr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // async reset issued between edges; checks take effect without a clock
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        set_idle();
        #1;
        chk({tag, " rst pc"}, pc, 0);
        chk({tag, " rst cnt"}, cnt, 0);
        chk({tag, " rst flags"}, {halted, fault, wrap}, 0);
        cyc();
        chk({tag, " rst hold pc"}, pc, 0);
        m_pc = 0; m_cnt = 0; m_state = 0; m_stepq = 0; m_wrap = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_edge();
        logic        edge_s, adv, nonseq;
        logic [31:0] tgt;
        edge_s = step && !m_stepq;
        adv    = (m_state == 0) && pc_write && (!mode || edge_s);
        m_wrap = 1'b0;
        if (adv) begin
            if (halt) begin
                m_state = 1;
            end else begin
                nonseq = 1'b1;
                tgt    = 0;
                if (jr) tgt = jr_addr;
                else if (jmp) tgt = jmp_addr;
                else if (br) tgt = br_addr;
                else nonseq = 1'b0;
                if (nonseq) begin
                    if ((tgt % 4) != 0 || tgt >= 1024) m_state = 2;
                    else begin
                        m_pc = tgt;
                        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                    end
                end else begin
                    m_pc   = (m_pc + 4) % 1024;
                    m_wrap = (m_pc == 0);
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                end
            end
        end else if (m_state == 1 && resume) begin
            m_state = 0;
        end
        m_stepq = step;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom % 16;
        if (r == 0) return $urandom;
        if (r == 1) return $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
        return $urandom_range(0, 255) * 4;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        set_idle();

        vecs[0]  = mk(1, 0, 0,      0, 0,      0, 0,      0, 0, 32'h4,   0, 0, 0, 1);
        vecs[1]  = mk(1, 0, 0,      0, 0,      1, 'h100,  0, 0, 32'h100, 0, 0, 0, 2);
        vecs[2]  = mk(1, 0, 0,      1, 'h80,   1, 'hC0,   0, 0, 32'h80,  0, 0, 0, 3);
        vecs[3]  = mk(1, 1, 'h40,   1, 'h80,   1, 'hC0,   0, 0, 32'h40,  0, 0, 0, 4);
        vecs[4]  = mk(0, 0, 0,      1, 'h200,  0, 0,      0, 0, 32'h40,  0, 0, 0, 4);
        vecs[5]  = mk(1, 0, 0,      1, 'h10,   0, 0,      1, 0, 32'h40,  1, 0, 0, 4);
        vecs[6]  = mk(1, 0, 0,      1, 'h10,   0, 0,      0, 1, 32'h40,  0, 0, 0, 4);
        vecs[7]  = mk(1, 0, 0,      0, 0,      0, 0,      0, 0, 32'h44,  0, 0, 0, 5);
        vecs[8]  = mk(1, 0, 0,      1, 'h3FC,  0, 0,      0, 0, 32'h3FC, 0, 0, 0, 6);
        vecs[9]  = mk(1, 0, 0,      0, 0,      0, 0,      0, 0, 32'h0,   0, 0, 1, 7);
        vecs[10] = mk(1, 0, 0,      0, 0,      0, 0,      0, 0, 32'h4,   0, 0, 0, 8);
        vecs[11] = mk(1, 0, 0,      0, 0,      1, 'h42,   0, 0, 32'h4,   0, 1, 0, 8);
        vecs[12] = mk(1, 0, 0,      0, 0,      0, 0,      0, 0, 32'h4,   0, 1, 0, 8);
        vecs[13] = mk(1, 0, 0,      0, 0,      0, 0,      0, 1, 32'h4,   0, 1, 0, 8);

        repeat (2) cyc();
        chk("por pc", pc, 0);
        chk("por cnt", cnt, 0);
        chk("por flags", {halted, fault, wrap}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            pc_write = vecs[i].pcw; jr = vecs[i].jr; jr_addr = vecs[i].jr_a;
            jmp = vecs[i].jmp; jmp_addr = vecs[i].jmp_a; br = vecs[i].br;
            br_addr = vecs[i].br_a; halt = vecs[i].halt; resume = vecs[i].resume;
            cyc();
            chk($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("vec%0d pc4", i), pc4, vecs[i].e_pc + 4);
            chk($sformatf("vec%0d pc8", i), pc8, vecs[i].e_pc + 8);
            chk($sformatf("vec%0d halted", i), halted, vecs[i].e_halted);
            chk($sformatf("vec%0d fault", i), fault, vecs[i].e_fault);
            chk($sformatf("vec%0d wrap", i), wrap, vecs[i].e_wrap);
            chk($sformatf("vec%0d cnt", i), cnt, vecs[i].e_cnt);
        end

        // sequential run from reset
        do_reset("seq");
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("seq pc%0d", i), pc, 4 * i);
        end
        chk("seq cnt", cnt, 4);
        chk("seq pc8", pc8, 24);

        // step mode: held level yields one advance per rising edge
        do_reset("step");
        mode = 1'b1; step = 1'b1;
        repeat (5) cyc();
        step = 1'b0;
        repeat (2) cyc();
        step = 1'b1;
        repeat (2) cyc();
        step = 1'b0;
        repeat (2) cyc();
        chk("step cnt", cnt, 2);
        chk("step pc", pc, 8);

        // step edge during stall is dropped
        do_reset("stall");
        mode = 1'b1; step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        step = 1'b1; pc_write = 1'b0;
        cyc();
        pc_write = 1'b1;
        repeat (3) cyc();
        step = 1'b0;
        cyc();
        chk("stall cnt", cnt, 1);
        chk("stall pc", pc, 4);

        // halt at PC 8, hold, resume, continue
        do_reset("halt");
        repeat (2) cyc();
        chk("halt pre pc", pc, 8);
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        chk("halt entered", halted, 1);
        chk("halt pc", pc, 8);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("halt hold pc %0d", i), pc, 8);
            chk($sformatf("halt hold flag %0d", i), halted, 1);
        end
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        chk("resume flag", halted, 0);
        chk("resume pc", pc, 8);
        cyc();
        chk("resume next pc", pc, 12);
        chk("resume cnt", cnt, 3);

        // asynchronous reset mid-run at PC 0x20
        do_reset("mid0");
        repeat (8) cyc();
        chk("mid pc", pc, 32'h20);
        do_reset("mid");

        // randomized run against the reference model
        for (int n = 0; n < 2000; n++) begin
            if ((m_state == 2 && ($urandom % 4) == 0) || ($urandom % 400) == 0) begin
                do_reset($sformatf("rnd%0d", n));
            end
            mode     = (($urandom % 4) == 0);
            step     = $urandom % 2;
            pc_write = (($urandom % 8) != 0);
            jr       = (($urandom % 10) == 0);
            jmp      = (($urandom % 10) == 0);
            br       = (($urandom % 6) == 0);
            jr_addr  = rnd_addr();
            jmp_addr = rnd_addr();
            br_addr  = rnd_addr();
            halt     = (($urandom % 25) == 0);
            resume   = (($urandom % 4) == 0);
            model_edge();
            cyc();
            chk($sformatf("rnd%0d pc", n), pc, m_pc);
            chk($sformatf("rnd%0d cnt", n), cnt, m_cnt);
            chk($sformatf("rnd%0d halted", n), halted, m_state == 1);
            chk($sformatf("rnd%0d fault", n), fault, m_state == 2);
            chk($sformatf("rnd%0d wrap", n), wrap, m_wrap);
        end
        set_idle();

        // small instance: wrap after PC 12 and counter saturation
        chk("d2 rst pc", d2_pc, 0);
        chk("d2 rst cnt", d2_cnt, 0);
        @(negedge clk);
        rst2_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk($sformatf("d2 pc%0d", i), d2_pc, (4 * i) % 16);
            chk($sformatf("d2 wrap%0d", i), d2_wrap, ((4 * i) % 16) == 0);
            chk($sformatf("d2 cnt%0d", i), d2_cnt, (i > 7) ? 7 : i);
        end
        chk("d2 flags", {d2_halted, d2_fault}, 0);
        chk("d2 pc8", d2_pc8, d2_pc + 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_ctrl

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter SIZE_ADDR_PC, default 32: PC and target address width in bits.
REQ-002 Parameter IMEM_DEPTH, default 256: instruction memory depth in 32-bit words, power of two.
REQ-003 Parameter RESET_ADDR, default 0: PC value after reset, word-aligned.
REQ-004 Parameter SIZE_CNT, default 32: advance counter width.
REQ-005 i_clk  in  1  single clock, rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_mode  in  1  0 = continuous run, 1 = debug step.
REQ-008 i_step  in  1  debug step request, level; rising edge detected internally.
REQ-009 i_pc_write  in  1  hazard-unit enable; 0 = stall, PC holds.
REQ-010 i_branch_taken / i_branch_addr  in  1 / SIZE_ADDR_PC  taken branch and target.
REQ-011 i_jump / i_jump_addr  in  1 / SIZE_ADDR_PC  J/JAL and target.
REQ-012 i_jr / i_jr_addr  in  1 / SIZE_ADDR_PC  JR/JALR and register target.
REQ-013 i_halt  in  1  HALT instruction decoded.
REQ-014 i_resume  in  1  leave HALT.
REQ-015 o_pc, o_pc_4, o_pc_8  out  SIZE_ADDR_PC each  current PC, PC+4, PC+8 (link value).
REQ-016 o_halted, o_fault  out  1 each  in HALT / in FAULT.
REQ-017 o_wrap  out  1  one-cycle pulse when sequential PC wraps.
REQ-018 o_adv_count  out  SIZE_CNT  number of PC advances since reset.

Function
REQ-019 FSM states RUN, HALT, FAULT; reset state RUN.
REQ-020 Advance enable adv = (state==RUN) & i_pc_write & (i_mode==0 | step_edge), step_edge = i_step & ~i_step_q, i_step_q registered.
REQ-021 In step mode, exactly one advance per i_step rising edge; a step edge coinciding with i_pc_write=0 is consumed, not queued.
REQ-022 Next-PC priority: i_jr > i_jump > i_branch_taken > sequential; update on rising clock edge when adv=1, latency one cycle.
REQ-023 Sequential target = (o_pc + 4) modulo (IMEM_DEPTH*4); wrap to 0 asserts o_wrap for the following cycle.
REQ-024 o_pc_4 = o_pc + 4 and o_pc_8 = o_pc + 8, combinational, width SIZE_ADDR_PC, no modulo.
REQ-025 Selected non-sequential target with bits[1:0] != 0 or >= IMEM_DEPTH*4: PC holds, state -> FAULT, o_fault=1.
REQ-026 FAULT is terminal; only reset exits.
REQ-027 i_halt with adv=1: PC holds, no count increment, state -> HALT, o_halted=1.
REQ-028 i_halt takes precedence over all targets in the same cycle.
REQ-029 HALT -> RUN on i_resume=1; PC unchanged in the transition cycle.
REQ-030 i_resume outside HALT ignored.
REQ-031 o_adv_count increments on each PC update and saturates at all-ones.
REQ-032 With adv=0, PC, count and state hold (HALT/FAULT entry requires adv=1).

Reset
REQ-033 i_reset=0 asynchronously forces o_pc=RESET_ADDR, state RUN, o_adv_count=0, o_wrap=0, o_halted=0, o_fault=0, i_step_q=0.
REQ-034 Reset asserted mid-step or mid-HALT discards pending step edge and resume.
REQ-035 First advance possible on the first rising edge after i_reset deasserts.

Structure
REQ-036 FSM state encoding and the instruction byte stride (4) in the shared MIPS package.
REQ-037 One sub-module, pc_next_sel: combinational target priority mux plus misalignment/range check.

Verification
REQ-038 Reset release, i_mode=0, i_pc_write=1, 4 cycles -> o_pc 0,4,8,12,16; o_adv_count=4; o_pc_8=24 at PC 16.
REQ-039 i_mode=1, i_step held high 5 cycles then low, again high -> exactly 2 advances total; i_pc_write=0 on second edge -> 1 advance.
REQ-040 Same cycle i_jr=1 (0x40), i_jump=1 (0x80), i_branch_taken=1 (0xC0) -> o_pc=0x40; i_branch_addr=0x42 alone -> o_fault=1, PC holds, stays FAULT.
REQ-041 IMEM_DEPTH=4, run from 0 -> PC 12 then 0, o_wrap high one cycle.
REQ-042 i_halt at PC 8 -> o_halted=1, PC 8 held 10 cycles; i_resume -> RUN, next advance PC 12.
REQ-043 i_reset low mid-run at PC 0x20 between edges -> o_pc=0 immediately, count 0.
